// File: rtl/tone_arbiter_if.sv
// Request/grant/tone bundle between the note requesters and tone_arbiter.
// master: drives req/noteN, slave: drives grant/done/aborted/piezo_out/led_out/busy.
interface tone_arbiter_if;
  logic [2:0] req;
  logic [3:0] note0;
  logic [3:0] note1;
  logic [3:0] note2;
  logic [2:0] grant;
  logic [2:0] done;
  logic       aborted;
  logic [3:0] piezo_out;
  logic [3:0] led_out;
  logic       busy;

  modport master (
    output req, note0, note1, note2,
    input  grant, done, aborted, piezo_out, led_out, busy
  );

  modport slave (
    input  req, note0, note1, note2,
    output grant, done, aborted, piezo_out, led_out, busy
  );
endinterface

// File: rtl/tone_arbiter.sv
// Three-way priority arbiter for a piezo: grants one note, plays it NOTE_LEN
// ticks, then GAP_LEN silent ticks.
// Ports: clk, reset (async, active-high), bus (tone_arbiter_if.slave):
//   req/note0..2 in; grant/done/aborted pulses, piezo_out/led_out, busy out.
// Optional macro ALERT_PREEMPT_EN: alert (req[2]) cuts short a note of 0/1.
module tone_arbiter #(
  parameter int TICK_DIV = 4,
  parameter int NOTE_LEN = 3,
  parameter int GAP_LEN  = 1
) (
  input logic           clk,
  input logic           reset,
  tone_arbiter_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int NOTE_LAST = NOTE_LEN - 1;
  localparam int GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]  note_q, note_d;
  logic [1:0]  owner_q, owner_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  done_q, done_d;
  logic [3:0]  out_q, out_d;
`ifdef ALERT_PREEMPT_EN
  logic        abort_q, abort_d;
`endif

  logic        tick;
  logic [1:0]  pick;
  logic [3:0]  pick_note;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Fixed priority: alert > keypad echo > playback.
  always_comb begin
    pick = 2'd0;
    if (bus.req[2]) begin
      pick = 2'd2;
    end else if (bus.req[1]) begin
      pick = 2'd1;
    end
  end

  always_comb begin
    pick_note = bus.note0;
    if (pick == 2'd2) begin
      pick_note = bus.note2;
    end else if (pick == 2'd1) begin
      pick_note = bus.note1;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    note_d  = note_q;
    owner_d = owner_q;
    grant_d = 3'b000;
    done_d  = 3'b000;
    out_d   = out_q;
`ifdef ALERT_PREEMPT_EN
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        out_d   = 4'd0;
        if (|bus.req) begin
          state_d = NOTE;
          owner_d = pick;
          grant_d = 3'b001 << pick;
          note_d  = pick_note;
          out_d   = pick_note;
        end
      end
      NOTE: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          tcnt_d = tcnt_q + CW'(1);
          if (tcnt_q == CW'(NOTE_LAST)) begin
            tcnt_d = '0;
            out_d  = 4'd0;
            if (GAP_LEN == 0) begin
              state_d = IDLE;
              done_d  = 3'b001 << owner_q;
            end else begin
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          tcnt_d = tcnt_q + CW'(1);
          if (tcnt_q == CW'(GAP_LAST)) begin
            tcnt_d  = '0;
            state_d = IDLE;
            done_d  = 3'b001 << owner_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 4'd0;
      end
    endcase
`ifdef ALERT_PREEMPT_EN
    // Alert takes over in a single edge; an alert never preempts an alert.
    if (state_q != IDLE && bus.req[2] && owner_q != 2'd2) begin
      done_d  = 3'b001 << owner_q;
      abort_d = 1'b1;
      grant_d = 3'b100;
      owner_d = 2'd2;
      note_d  = bus.note2;
      out_d   = bus.note2;
      presc_d = '0;
      tcnt_d  = '0;
      state_d = NOTE;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      note_q  <= 4'd0;
      owner_q <= 2'd0;
      grant_q <= 3'b000;
      done_q  <= 3'b000;
      out_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      note_q  <= note_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

`ifdef ALERT_PREEMPT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
  assign bus.aborted = abort_q;
`else
  assign bus.aborted = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.piezo_out = out_q;
  assign bus.led_out   = out_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter (TICK_DIV=4, NOTE_LEN=3, GAP_LEN=1).
// Stimulus pushes expected grants/dones; a negedge monitor pops and checks.
module tb_tone_arbiter;

  localparam int NOTE_CYC = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tone_arbiter_if bus ();

  tone_arbiter #(
    .TICK_DIV(4),
    .NOTE_LEN(3),
    .GAP_LEN (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] v;
    logic [3:0] note;
    logic       ab;
    int         len;
    int         gap;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] v, input logic [3:0] note,
                              input logic ab, input int len, input int gap);
    exp_t e;
    e.v = v;
    e.note = note;
    e.ab = ab;
    e.len = len;
    e.gap = gap;
    return e;
  endfunction

  // Monitor: "since" is the cycle index relative to the last grant cycle.
  int cyc = 0;
  int since = 0;
  int last_done = -100;
  bit active = 1'b0;
  logic [3:0] cur = 4'd0;
  logic [3:0] exp_out;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      active = 1'b0;
      since = 0;
    end else begin
      if (bus.done != 3'b000) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          me = dq.pop_front();
          chk("done", 32'(bus.done), 32'(me.v));
          chk("aborted", 32'(bus.aborted), 32'(me.ab));
          chk("note_len", 32'(since), 32'(me.len));
        end
        active = 1'b0;
        last_done = cyc;
      end else begin
        chk("aborted_no_done", 32'(bus.aborted), 32'd0);
      end
      if (bus.grant != 3'b000) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(bus.grant), 32'd0);
        end else begin
          me = gq.pop_front();
          chk("grant", 32'(bus.grant), 32'(me.v));
          if (me.gap >= 0) chk("grant_after_done", 32'(cyc - last_done), 32'(me.gap));
          cur = me.note;
        end
        active = 1'b1;
        since = 0;
      end
      exp_out = (active && since < NOTE_CYC) ? cur : 4'd0;
      chk("piezo_out", 32'(bus.piezo_out), 32'(exp_out));
      chk("led_out", 32'(bus.led_out), 32'(exp_out));
      chk("busy", 32'(bus.busy), 32'(active));
      since++;
    end
  end

  task automatic wait_grant(input int idx);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #2;
      got = bus.grant[idx];
    end
    if (!got) begin
      checks++;
      errs++;
      $display("FAIL grant_timeout: got no grant[%0d] expected a pulse", idx);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(posedge clk);
      #2;
      idle = !bus.busy;
    end
    if (!idle) begin
      checks++;
      errs++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000;
    bus.note0 = 4'd0;
    bus.note1 = 4'd0;
    bus.note2 = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_aborted", 32'(bus.aborted), 32'd0);
    chk("rst_piezo", 32'(bus.piezo_out), 32'd0);
    chk("rst_led", 32'(bus.led_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Single playback note; note0 change after grant must not matter.
    gq.push_back(mk(3'b001, 4'd5, 1'b0, 0, -1));
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd5;
    bus.req = 3'b001;
    wait_grant(0);
    bus.req = 3'b000;
    bus.note0 = 4'd9;
    wait_idle();

    // Keypad beats playback; playback follows one cycle after done.
    gq.push_back(mk(3'b010, 4'd7, 1'b0, 0, -1));
    dq.push_back(mk(3'b010, 4'd0, 1'b0, 16, -1));
    gq.push_back(mk(3'b001, 4'd2, 1'b0, 0, 1));
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd2;
    bus.note1 = 4'd7;
    bus.req = 3'b011;
    wait_grant(1);
    bus.req[1] = 1'b0;
    wait_grant(0);
    bus.req[0] = 1'b0;
    wait_idle();

    // Rest note: silent but fully timed.
    gq.push_back(mk(3'b001, 4'd0, 1'b0, 0, -1));
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd0;
    bus.req = 3'b001;
    wait_grant(0);
    bus.req = 3'b000;
    wait_idle();

    // Alert arriving in cycle 4 of a playback note.
    gq.push_back(mk(3'b001, 4'd3, 1'b0, 0, -1));
`ifdef ALERT_PREEMPT_EN
    dq.push_back(mk(3'b001, 4'd0, 1'b1, 5, -1));
    gq.push_back(mk(3'b100, 4'd15, 1'b0, 0, 0));
`else
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    gq.push_back(mk(3'b100, 4'd15, 1'b0, 0, 1));
`endif
    dq.push_back(mk(3'b100, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd3;
    bus.req = 3'b001;
    wait_grant(0);
    bus.req = 3'b000;
    repeat (4) @(posedge clk);
    #2;
    bus.note2 = 4'd15;
    bus.req[2] = 1'b1;
    wait_grant(2);
    bus.req[2] = 1'b0;
    wait_idle();

    // Reset mid-note: silent at once, no done for the lost note.
    gq.push_back(mk(3'b001, 4'd6, 1'b0, 0, -1));
    bus.note0 = 4'd6;
    bus.req = 3'b001;
    wait_grant(0);
    bus.req = 3'b000;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_piezo", 32'(bus.piezo_out), 32'd0);
    chk("midrst_led", 32'(bus.led_out), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    gq.push_back(mk(3'b001, 4'd4, 1'b0, 0, -1));
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd4;
    bus.req = 3'b001;
    wait_grant(0);
    bus.req = 3'b000;
    wait_idle();

    // A playback request pulsed during a note is forgotten.
    gq.push_back(mk(3'b010, 4'd8, 1'b0, 0, -1));
    dq.push_back(mk(3'b010, 4'd0, 1'b0, 16, -1));
    bus.note1 = 4'd8;
    bus.req = 3'b010;
    wait_grant(1);
    bus.req = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    bus.req[0] = 1'b1;
    @(posedge clk);
    #2;
    bus.req[0] = 1'b0;
    wait_idle();

    // All three at once: served 2, 1, 0, back to back.
    gq.push_back(mk(3'b100, 4'd1, 1'b0, 0, -1));
    dq.push_back(mk(3'b100, 4'd0, 1'b0, 16, -1));
    gq.push_back(mk(3'b010, 4'd4, 1'b0, 0, 1));
    dq.push_back(mk(3'b010, 4'd0, 1'b0, 16, -1));
    gq.push_back(mk(3'b001, 4'd3, 1'b0, 0, 1));
    dq.push_back(mk(3'b001, 4'd0, 1'b0, 16, -1));
    bus.note0 = 4'd3;
    bus.note1 = 4'd4;
    bus.note2 = 4'd1;
    bus.req = 3'b111;
    wait_grant(2);
    bus.req[2] = 1'b0;
    wait_grant(1);
    bus.req[1] = 1'b0;
    wait_grant(0);
    bus.req[0] = 1'b0;
    wait_idle();

    chk("grants_left", 32'(gq.size()), 32'd0);
    chk("dones_left", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per timing tick, >=1.
REQ-002 Parameter NOTE_LEN, default 3: ticks a granted note drives outputs, >=1.
REQ-003 Parameter GAP_LEN, default 1: silent ticks after each note, >=0.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req  input  3  per-requester note request, level, held until grant (0=playback, 1=keypad echo, 2=alert).
REQ-007 note0, note1, note2  input  4 each  note code for requester 0/1/2, sampled at grant.
REQ-008 grant  output  3  one-hot, one-cycle pulse: request accepted and note latched.
REQ-009 done  output  3  one-hot, one-cycle pulse: granted note (and gap) finished or aborted.
REQ-010 aborted  output  1  one-cycle pulse coincident with done when the note was cut short.
REQ-011 piezo_out  output  4  note code to piezo driver, 0 = silent.
REQ-012 led_out  output  4  mirror of piezo_out.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, NOTE, GAP.
REQ-015 In IDLE, the block SHALL grant the highest-index asserted req (2 > 1 > 0); the grant, the latch of the matching noteN, the transition to NOTE, and piezo_out/led_out = latched note SHALL all take effect on the same edge.
REQ-016 A req withdrawn before its grant SHALL be treated as never made; the block SHALL NOT remember pending requests.
REQ-017 A tick SHALL be produced every TICK_DIV clocks by a prescaler cleared on every grant, so NOTE lasts exactly NOTE_LEN*TICK_DIV cycles.
REQ-018 NOTE->GAP after NOTE_LEN ticks; outputs SHALL go to 0 on that edge; GAP lasts GAP_LEN*TICK_DIV cycles.
REQ-019 With GAP_LEN=0, NOTE SHALL go directly to IDLE.
REQ-020 On the edge entering IDLE from NOTE/GAP, done[owner] SHALL pulse for one cycle; the earliest next grant SHALL be the following edge (no grant in the done cycle).
REQ-021 Note code 0 SHALL be a timed rest: full NOTE/GAP timing, outputs stay 0, grant/done still pulse.
REQ-022 Requests arriving during NOTE/GAP SHALL wait (held req) and be arbitrated at the next IDLE, except as in REQ-027.
REQ-023 At most one grant bit and at most one done bit SHALL be high in any cycle.
REQ-024 Changes to noteN after grant SHALL NOT affect the playing note.

Reset
REQ-025 On reset: state IDLE, prescaler and tick counter 0, latched note 0, owner 0, grant=0, done=0, aborted=0, piezo_out=0, led_out=0, busy=0.
REQ-026 Reset asserted mid-note SHALL silence outputs immediately and SHALL NOT emit done for the interrupted note.

Configuration
REQ-027 With ALERT_PREEMPT_EN defined: req[2] asserted while owner is 0 or 1 in NOTE or GAP SHALL, on one edge, pulse done[owner] and aborted, pulse grant[2], latch note2, restart the prescaler and enter NOTE; an alert never preempts an alert.
REQ-028 Without ALERT_PREEMPT_EN: req[2] waits like any request per REQ-022, and aborted SHALL be constant 0.

Verification (TICK_DIV=4, NOTE_LEN=3, GAP_LEN=1)
REQ-029 req[0]=1, note0=5 from IDLE -> grant=3'b001 one cycle; piezo_out=led_out=5 for 12 cycles; 0 for 4 cycles; done=3'b001 pulse; busy high 16 cycles.
REQ-030 req=3'b011 simultaneously, note0=2, note1=7 -> grant[1] first, piezo_out=7; after done[1], next edge grant[0], piezo_out=2.
REQ-031 note0=0 requested -> 16 cycles busy with piezo_out=0, grant[0] and done[0] still pulse.
REQ-032 ALERT_PREEMPT_EN defined, req[2]=1 note2=15 at cycle 5 of a note0=3 NOTE -> same edge: done[0], aborted, grant[2], piezo_out=15 for 12 cycles; without macro -> note 3 completes, grant[2] follows done[0] by one cycle.
REQ-033 reset pulsed at cycle 6 of a note -> piezo_out=0, busy=0, no done pulse; new req after release granted normally.
REQ-034 req[0] pulsed for 1 cycle during a NOTE then dropped -> no grant[0] ever issued.
